// File: rtl/powlib_pktarb.sv
// powlib_pktarb
//   Packet-aware round-robin arbiter. N requesters share one valid/ready
//   sink. A granted requester keeps the sink until its end-of-packet beat
//   (bit W-1 set) is taken, so packets are never interleaved.
//
// Ports
//   clk      block clock
//   rst      asynchronous, active-high reset
//   indata   requester words, requester i at [i*W +: W]
//   invld    per-requester valid
//   inrdy    per-requester ready
//   outdata  word to sink
//   outvld   valid to sink
//   outrdy   ready from sink
//   grant    one-hot current owner, all zero when idle
//   busy     high while a packet is locked
//
// Build option
//   POWLIB_PKTARB_OUTREG_EN  registers the sink side through a 2-entry skid
//                            buffer so outrdy no longer reaches inrdy
//                            combinationally (beat latency becomes 1).
module powlib_pktarb #(
  parameter int W  = 33,
  parameter int N  = 3,
  parameter     ID = "PKTARB"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] indata,
  input  logic [N-1:0]   invld,
  output logic [N-1:0]   inrdy,
  output logic [W-1:0]   outdata,
  output logic           outvld,
  input  logic           outrdy,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pointer, pointer_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [N-1:0]  grant_nxt;
  logic          busy_nxt;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [W-1:0]  owner_word;
  logic          owner_vld;
  logic          accept;
  logic          eop;

  // Round-robin search: first requesting index starting just after the
  // last packet's owner, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!sel_found && invld[i] && (((int'(pointer) + k) % N) == i)) begin
          sel_found = 1'b1;
          sel_idx   = PW'(i);
        end
      end
    end
  end

  // Mux the owner's word and valid out of the flattened request bus.
  always_comb begin
    owner_word = '0;
    owner_vld  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner == PW'(i)) begin
        owner_word = indata[i*W +: W];
        owner_vld  = invld[i];
      end
    end
  end

`ifdef POWLIB_PKTARB_OUTREG_EN
  // Two-entry skid buffer between the owner and the sink. The owner is
  // accepted whenever an entry is free, so a buffer holding one word can
  // push and pop in the same cycle and keep 1 beat/cycle.
  logic [W-1:0] skid [2];
  logic [1:0]   count;
  logic         wr_ptr, rd_ptr;
  logic         room, pop;

  assign room    = (count != 2'd2);
  assign accept  = (state == LOCK) && owner_vld && room;
  assign pop     = outvld && outrdy;
  assign outvld  = (count != 2'd0);
  assign outdata = skid[rd_ptr];

  always_comb begin
    inrdy = '0;
    for (int i = 0; i < N; i++) begin
      if (state == LOCK && owner == PW'(i)) inrdy[i] = room;
    end
  end

  // Buffer storage and pointers; reset empties both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid[0] <= '0;
      skid[1] <= '0;
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      if (accept) begin
        skid[wr_ptr] <= owner_word;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(accept) - 2'(pop);
    end
  end
`else
  // Combinational pass-through from the owner to the sink.
  assign outvld  = (state == LOCK) && owner_vld;
  assign outdata = (state == LOCK) ? owner_word : '0;
  assign accept  = outvld && outrdy;

  always_comb begin
    inrdy = '0;
    for (int i = 0; i < N; i++) begin
      if (state == LOCK && owner == PW'(i)) inrdy[i] = outrdy;
    end
  end
`endif

  // The packet closes when its flagged beat leaves the owner.
  assign eop = accept && owner_word[W-1];

  // State and arbitration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pointer <= PW'(N-1);
      owner   <= '0;
      grant   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pointer <= pointer_nxt;
      owner   <= owner_nxt;
      grant   <= grant_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the lock until end of packet.
  always_comb begin
    state_nxt   = state;
    pointer_nxt = pointer;
    owner_nxt   = owner;
    grant_nxt   = grant;
    busy_nxt    = busy;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt          = LOCK;
          owner_nxt          = sel_idx;
          grant_nxt          = '0;
          grant_nxt[sel_idx] = 1'b1;
          busy_nxt           = 1'b1;
        end
      end
      LOCK: begin
        if (eop) begin
          state_nxt   = IDLE;
          pointer_nxt = owner;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A requester must never see ready while the arbiter is still deciding.
  idle_rdy_chk: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && (|invld) && (|inrdy)))
    else $error("%s: invld high in IDLE while inrdy asserted", ID);

endmodule

// File: tb/tb_powlib_pktarb.sv
// tb_powlib_pktarb
//   Directed bench for powlib_pktarb (W=33, N=3). Each requester is fed
//   from a word queue; transfers seen at the sink are logged with the
//   cycle they happened in and compared against hand-built sequences.
module tb_powlib_pktarb;

  localparam int W = 33;
  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] indata;
  logic [N-1:0]   invld;
  logic [N-1:0]   inrdy;
  logic [W-1:0]   outdata;
  logic           outvld;
  logic           outrdy;
  logic [N-1:0]   grant;
  logic           busy;

  logic [W-1:0] src_q [N][$];
  logic [W-1:0] out_log [$];
  int           out_cyc [$];
  logic [W-1:0] exp_q [$];
  int           cyc;
  int           n_checks;
  int           n_fail;

  localparam logic [W-1:0] FLAG = {1'b1, 32'h0};

  powlib_pktarb #(.W(W), .N(N), .ID("PKTARB")) dut (
    .clk(clk), .rst(rst),
    .indata(indata), .invld(invld), .inrdy(inrdy),
    .outdata(outdata), .outvld(outvld), .outrdy(outrdy),
    .grant(grant), .busy(busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present each queue head to the arbiter.
  task automatic applyStimulus();
    indata = '0;
    invld  = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        invld[i]         = 1'b1;
        indata[i*W +: W] = src_q[i][0];
      end
    end
  endtask

  // One clock: sample handshakes before the edge, pop and re-drive after.
  task automatic tick();
    logic [N-1:0] hs;
    hs = invld & inrdy;
    if (!rst && outvld && outrdy) begin
      out_log.push_back(outdata);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    #1;
    applyStimulus();
    #1;
  endtask

  // Run until n sink transfers are logged or the budget runs out.
  task automatic waitLog(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    checkOutput(tag, 64'(out_log.size()), 64'(n));
  endtask

  task automatic checkLog(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < out_log.size()) checkOutput(tag, 64'(out_log[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic clearLogs();
    out_log.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    outrdy   = 1'b1;
    applyStimulus();

    // Reset then idle for 10 cycles.
    @(posedge clk);
    #1;
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("idle_grant", 64'(grant), 64'h0);
      checkOutput("idle_busy", 64'(busy), 64'h0);
      checkOutput("idle_outvld", 64'(outvld), 64'h0);
      checkOutput("idle_inrdy", 64'(inrdy), 64'h0);
    end

    // Single requester, 4-beat packet.
    $display("[TB] single requester");
    clearLogs();
    src_q[0] = '{33'h1, 33'h2, 33'h3, 33'h1_0000_0004};
    exp_q    = '{33'h1, 33'h2, 33'h3, 33'h1_0000_0004};
    applyStimulus();
    #1;
    checkOutput("single_arb_grant", 64'(grant), 64'h0);
    checkOutput("single_arb_outvld", 64'(outvld), 64'h0);
    tick();
    checkOutput("single_grant", 64'(grant), 64'h1);
    checkOutput("single_busy", 64'(busy), 64'h1);
`ifndef POWLIB_PKTARB_OUTREG_EN
    checkOutput("single_outvld", 64'(outvld), 64'h1);
    checkOutput("single_outdata", 64'(outdata), 64'h1);
    checkOutput("single_inrdy", 64'(inrdy), 64'h1);
`endif
    while (src_q[0].size() > 0 && cyc < 200) tick();
    checkOutput("single_busy_end", 64'(busy), 64'h0);
    checkOutput("single_grant_end", 64'(grant), 64'h0);
    waitLog("single_count", 4, 20);
    checkLog("single_word");
    for (int k = 1; k < out_cyc.size(); k++)
      checkOutput("single_contig", 64'(out_cyc[k] - out_cyc[k-1]), 64'h1);
    tick();
    checkOutput("single_drained", 64'(outvld), 64'h0);

    // Contention: every requester sends two 2-beat packets.
    $display("[TB] contention");
    resetPulse();
    clearLogs();
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 2; p++) begin
        src_q[i].push_back(33'((i << 4) | (2*p + 1)));
        src_q[i].push_back(FLAG | 33'((i << 4) | (2*p + 2)));
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(33'((i << 4) | (2*p + 1)));
        exp_q.push_back(FLAG | 33'((i << 4) | (2*p + 2)));
      end
    end
    applyStimulus();
    #1;
    waitLog("cont_count", 12, 100);
    checkLog("cont_word");
`ifndef POWLIB_PKTARB_OUTREG_EN
    for (int k = 1; k < out_cyc.size(); k++)
      checkOutput((k % 2) ? "cont_beat_gap" : "cont_pkt_gap",
                  64'(out_cyc[k] - out_cyc[k-1]), (k % 2) ? 64'h1 : 64'h2);
`endif

    // Backpressure on a 3-beat packet from requester 1.
    $display("[TB] backpressure");
    for (int c = 0; c < 4; c++) tick();
    clearLogs();
    src_q[1] = '{33'h101, 33'h102, 33'h1_0000_0103};
    exp_q    = '{33'h101, 33'h102, 33'h1_0000_0103};
    applyStimulus();
    #1;
    tick();
    checkOutput("bp_grant", 64'(grant), 64'h2);
    begin
      logic pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 4; c++) begin
        outrdy = pat[c];
        #1;
`ifndef POWLIB_PKTARB_OUTREG_EN
        checkOutput("bp_inrdy_mirror", 64'(inrdy), pat[c] ? 64'h2 : 64'h0);
        checkOutput("bp_outvld", 64'(outvld), 64'h1);
`endif
        tick();
      end
    end
    outrdy = 1'b1;
    waitLog("bp_count", 3, 30);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("bp_no_dup", 64'(out_log.size()), 64'h3);
    checkLog("bp_word");

    // Reset in the middle of a 4-beat packet from requester 2.
    $display("[TB] reset mid-packet");
    clearLogs();
    src_q[2] = '{33'h201, 33'h202, 33'h203, 33'h1_0000_0204};
    applyStimulus();
    #1;
    begin
      int c;
      c = 0;
      while (src_q[2].size() > 2 && c < 30) begin
        tick();
        c++;
      end
    end
    checkOutput("mid_busy_before", 64'(busy), 64'h1);
    checkOutput("mid_grant_before", 64'(grant), 64'h4);
    rst = 1'b1;
    #1;
    checkOutput("mid_outvld", 64'(outvld), 64'h0);
    checkOutput("mid_grant", 64'(grant), 64'h0);
    checkOutput("mid_busy", 64'(busy), 64'h0);
    checkOutput("mid_inrdy", 64'(inrdy), 64'h0);
    src_q[2].delete();
    src_q[0].push_back(FLAG | 33'h0A);
    src_q[2].push_back(FLAG | 33'h2A);
    applyStimulus();
    clearLogs();
    exp_q = '{FLAG | 33'h0A, FLAG | 33'h2A};
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_grant", 64'(grant), 64'h0);
    tick();
    checkOutput("post_rst_winner", 64'(grant), 64'h1);
    waitLog("post_rst_count", 2, 30);
    checkLog("post_rst_word");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
